// File: rtl/mod_det_nxn.sv
// mod_det_nxn: signed determinant of an NxN matrix (N = 2..5) using
// sequential fraction-free (Bareiss) elimination with row-swap pivoting.
// One element update per clock; the result is saturated to RES_W bits.
// resultado/ovf are loaded on the edge that enters OUT so that they are
// already valid in the cycle where done is high.
module mod_det_nxn #(
  parameter int N      = 5,
  parameter int DATA_W = 8,
  parameter int RES_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N*N*DATA_W-1:0] matrix_in,
  output logic [RES_W-1:0]      resultado,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done
);

  // Bareiss intermediates are minors of the input, so N*(DATA_W+1) bits
  // bounds them; the cross products need twice that.
  localparam int INT_W = N * (DATA_W + 1);
  localparam int PW    = 2 * INT_W;
  localparam int IW    = (N > 4) ? 3 : (N > 2) ? 2 : 1;

  localparam logic [IW-1:0] LAST   = IW'(N - 1);
  localparam logic [IW-1:0] PENULT = IW'(N - 2);

  localparam logic signed [INT_W-1:0] RMAX =
    {{(INT_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] RMIN =
    {{(INT_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, LOAD, PIVOT, SCAN, SWAP, ELIM, OUT
  } state_t;

  state_t state, nxt;

  // Working matrix, fully packed so that a whole row can be swapped in one go.
  logic [N-1:0][N-1:0][INT_W-1:0] a;
  logic [N-1:0][N-1:0][INT_W-1:0] ld;

  logic [IW-1:0] k, r, i, j;
  logic signed [INT_W-1:0] prev;
  logic                    neg;

  logic signed [INT_W-1:0] a_kk, a_ij, a_ik, a_kj, a_rk;
  logic signed [PW-1:0]    num, quot;
  logic signed [INT_W-1:0] upd, det;
  logic [RES_W-1:0]        sat_res;
  logic                    sat_ovf;
  logic                    elim_last, final_step;

  // Sign-extend every input element to the internal width.
  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      assign ld[gr][gc] = INT_W'($signed(matrix_in[(gr*N+gc)*DATA_W +: DATA_W]));
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == OUT);
  assign elim_last  = (i == LAST) && (j == LAST);
  assign final_step = (k == PENULT);

  // Bareiss cross-product update for element (i,j); the division is exact.
  always_comb begin
    a_kk = $signed(a[k][k]);
    a_ij = $signed(a[i][j]);
    a_ik = $signed(a[i][k]);
    a_kj = $signed(a[k][j]);
    a_rk = $signed(a[r][k]);
    num  = PW'(a_kk) * PW'(a_ij) - PW'(a_ik) * PW'(a_kj);
    quot = num / PW'(prev);
    upd  = INT_W'(quot);
  end

  // Final determinant and its saturation. Leaving SCAN means singular.
  always_comb begin
    if (state == SCAN) det = '0;
    else               det = neg ? -upd : upd;
    sat_res = det[RES_W-1:0];
    sat_ovf = 1'b0;
    if (det > RMAX) begin
      sat_res = RMAX[RES_W-1:0];
      sat_ovf = 1'b1;
    end else if (det < RMIN) begin
      sat_res = RMIN[RES_W-1:0];
      sat_ovf = 1'b1;
    end
  end

  // Next-state logic of the elimination sequencer.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = LOAD;
      LOAD:  nxt = PIVOT;
      PIVOT: nxt = (a_kk != '0) ? ELIM : SCAN;
      SCAN: begin
        if (a_rk != '0)     nxt = SWAP;
        else if (r == LAST) nxt = OUT;
      end
      SWAP:  nxt = ELIM;
      ELIM:  if (elim_last) nxt = final_step ? OUT : PIVOT;
      OUT:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Result registers, written only when the sequencer enters OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      resultado <= '0;
      ovf       <= 1'b0;
    end else if (nxt == OUT) begin
      resultado <= sat_res;
      ovf       <= sat_ovf;
    end
  end

  // Matrix, indices, previous pivot and sign. No reset: contents are
  // reinitialised by LOAD before they are ever used.
  always_ff @(posedge clk) begin
    case (state)
      LOAD: begin
        a    <= ld;
        k    <= '0;
        prev <= INT_W'(1);
        neg  <= 1'b0;
      end
      PIVOT: begin
        r <= k + 1'b1;
        i <= k + 1'b1;
        j <= k + 1'b1;
      end
      SCAN: begin
        if (a_rk == '0 && r != LAST) r <= r + 1'b1;
      end
      SWAP: begin
        a[k] <= a[r];
        a[r] <= a[k];
        neg  <= ~neg;
      end
      ELIM: begin
        // Row k and column k are never written during step k, so every
        // update in this step sees the pre-step pivot row and column.
        a[i][j] <= upd;
        if (j == LAST) begin
          j <= k + 1'b1;
          i <= i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
        if (elim_last) begin
          prev <= a_kk;
          k    <= k + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mod_det_nxn.sv
// Bench for mod_det_nxn: a 5x5 instance (defaults) and a 3x3 instance.
// Stimulus pushes expected result/ovf/latency into per-DUT queues; monitors
// pop and compare whenever done is seen.
module tb_mod_det_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst5, start5, ovf5, busy5, done5;
  logic [199:0] mat5;
  logic [15:0]  res5;
  logic         rst3, start3, ovf3, busy3, done3;
  logic [71:0]  mat3;
  logic [15:0]  res3;

  mod_det_nxn #(.N(5), .DATA_W(8), .RES_W(16)) dut5 (
    .clk(clk), .rst(rst5), .start(start5), .matrix_in(mat5),
    .resultado(res5), .ovf(ovf5), .busy(busy5), .done(done5));

  mod_det_nxn #(.N(3), .DATA_W(8), .RES_W(16)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .matrix_in(mat3),
    .resultado(res3), .ovf(ovf3), .busy(busy3), .done(done3));

  typedef struct {
    int val;
    bit ovf;
    int lat;
    int c0;
    int tag;
  } exp_t;

  exp_t q5[$];
  exp_t q3[$];
  exp_t e5, e3;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic logic [199:0] pack5(input int v[25]);
    logic [199:0] m;
    m = '0;
    for (int x = 0; x < 25; x++) m[x*8 +: 8] = 8'(v[x]);
    return m;
  endfunction

  function automatic logic [199:0] pack3(input int v[9]);
    logic [199:0] m;
    m = '0;
    for (int x = 0; x < 9; x++) m[x*8 +: 8] = 8'(v[x]);
    return m;
  endfunction

  function automatic logic [199:0] diag5(input int d0, d1, d2, d3, d4);
    logic [199:0] m;
    m = '0;
    m[0*8 +: 8]  = 8'(d0);
    m[6*8 +: 8]  = 8'(d1);
    m[12*8 +: 8] = 8'(d2);
    m[18*8 +: 8] = 8'(d3);
    m[24*8 +: 8] = 8'(d4);
    return m;
  endfunction

  // Scoreboard monitor, 5x5 instance.
  always @(negedge clk) begin
    if (done5 === 1'b1) begin
      if (q5.size() == 0) begin
        n_tot++;
        $display("FAIL dut5 spurious done: done=1 with no operation pending");
      end else begin
        e5 = q5.pop_front();
        chk($sformatf("dut5 v%0d resultado", e5.tag), $signed(res5), e5.val);
        chk($sformatf("dut5 v%0d ovf", e5.tag), ovf5, e5.ovf);
        chk($sformatf("dut5 v%0d latency", e5.tag), cyc - e5.c0, e5.lat);
      end
    end
  end

  // Scoreboard monitor, 3x3 instance.
  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_tot++;
        $display("FAIL dut3 spurious done: done=1 with no operation pending");
      end else begin
        e3 = q3.pop_front();
        chk($sformatf("dut3 v%0d resultado", e3.tag), $signed(res3), e3.val);
        chk($sformatf("dut3 v%0d ovf", e3.tag), ovf3, e3.ovf);
        chk($sformatf("dut3 v%0d latency", e3.tag), cyc - e3.c0, e3.lat);
      end
    end
  end

  // Issue one start pulse; cycle n of the operation is cyc == c0 + n.
  task automatic issue(input int d, input logic [199:0] m, input int val,
                       input bit ov, input int lat, input int tag);
    exp_t e;
    @(posedge clk); #1;
    if (d == 0) begin
      chk($sformatf("dut5 v%0d idle before start", tag), busy5, 0);
      mat5 = m; start5 = 1'b1;
    end else begin
      chk($sformatf("dut3 v%0d idle before start", tag), busy3, 0);
      mat3 = m[71:0]; start3 = 1'b1;
    end
    e.val = val; e.ovf = ov; e.lat = lat; e.c0 = cyc; e.tag = tag;
    if (d == 0) q5.push_back(e);
    else        q3.push_back(e);
    @(posedge clk); #1;
    if (d == 0) begin
      start5 = 1'b0;
      chk($sformatf("dut5 v%0d busy in cycle 1", tag), busy5, 1);
    end else begin
      start3 = 1'b0;
      chk($sformatf("dut3 v%0d busy in cycle 1", tag), busy3, 1);
    end
  endtask

  // Wait (bounded) until the monitor has consumed all expectations.
  task automatic drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? q5.size() : q3.size()) != 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      n_tot++;
      $display("FAIL dut%0d timeout: no done within 300 cycles", (d == 0) ? 5 : 3);
      if (d == 0) q5.delete(); else q3.delete();
    end
  endtask

  int m5[25];
  int m3[9];

  initial begin
    rst5 = 1'b1; rst3 = 1'b1; start5 = 1'b0; start3 = 1'b0;
    mat5 = '0; mat3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("dut5 reset resultado", res5, 0);
    chk("dut5 reset ovf", ovf5, 0);
    chk("dut5 reset busy", busy5, 0);
    chk("dut5 reset done", done5, 0);
    chk("dut3 reset resultado", res3, 0);
    chk("dut3 reset ovf", ovf3, 0);
    chk("dut3 reset busy", busy3, 0);
    chk("dut3 reset done", done3, 0);
    rst5 = 1'b0; rst3 = 1'b0;

    // 5x5: diagonal 2*3*4*5*6, then identity issued back-to-back (cycle T+1)
    issue(0, diag5(2, 3, 4, 5, 6), 720, 0, 36, 1);   drain(0);
    issue(0, diag5(1, 1, 1, 1, 1), 1, 0, 36, 2);     drain(0);
    // identity with rows 0/1 exchanged: one swap found at r=1 -> +2 cycles
    m5 = '{0,1,0,0,0, 1,0,0,0,0, 0,0,1,0,0, 0,0,0,1,0, 0,0,0,0,1};
    issue(0, pack5(m5), -1, 0, 38, 3);               drain(0);
    // first column zero: LOAD + PIVOT + 4 SCAN + OUT
    m5 = '{0,1,2,3,4, 0,5,6,7,8, 0,9,10,11,12, 0,13,14,15,16, 0,17,18,19,20};
    issue(0, pack5(m5), 0, 0, 7, 4);                 drain(0);
    // 127^5 and (-128)^5 saturate
    issue(0, diag5(127, 127, 127, 127, 127), 32767, 1, 36, 5);        drain(0);
    issue(0, diag5(-128, -128, -128, -128, -128), -32768, 1, 36, 6);  drain(0);
    issue(0, diag5(-2, 3, 4, 5, 6), -720, 0, 36, 7);                  drain(0);
    // lower triangular, nonzero below the pivot: det = 1*1*2*3*4
    m5 = '{1,0,0,0,0, 1,1,0,0,0, 1,1,2,0,0, 1,1,1,3,0, 1,1,1,1,4};
    issue(0, pack5(m5), 24, 0, 36, 8);               drain(0);

    // 3x3: det = 2*(3-2) - 0 + 1*(1-3) = 0 (pivots nonzero, full 9 cycles)
    m3 = '{2,0,1, 1,3,2, 1,1,1};
    issue(1, pack3(m3), 0, 0, 9, 10);                drain(1);
    // det = (1*5 - 2*3) * 1 = -1
    m3 = '{1,2,0, 3,5,0, 0,0,1};
    issue(1, pack3(m3), -1, 0, 9, 11);               drain(1);
    // permutation: swap at r=1 -> 11 cycles, det = -1
    m3 = '{0,1,0, 1,0,0, 0,0,1};
    issue(1, pack3(m3), -1, 0, 11, 12);              drain(1);

    // start pulsed during ELIM with a different matrix: must be ignored
    m3 = '{1,2,0, 3,5,0, 0,0,1};
    issue(1, pack3(m3), -1, 0, 9, 13);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m3 = '{2,0,1, 1,3,2, 1,1,2};
    mat3 = pack3(m3);
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    drain(1);
    repeat (15) @(negedge clk);
    chk("dut3 idle after ignored start", busy3, 0);

    // reset in the middle of ELIM: back to IDLE, no done, outputs cleared
    m3 = '{1,2,0, 3,5,0, 0,0,1};
    issue(1, pack3(m3), -1, 0, 9, 14);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    q3.delete();
    chk("dut3 busy after mid-op reset", busy3, 0);
    chk("dut3 done after mid-op reset", done3, 0);
    chk("dut3 resultado after mid-op reset", res3, 0);
    chk("dut3 ovf after mid-op reset", ovf3, 0);
    rst3 = 1'b0;
    repeat (12) @(negedge clk);
    // det = 2*(6-2) + 1*(1-3) = 6
    m3 = '{2,0,1, 1,3,2, 1,1,2};
    issue(1, pack3(m3), 6, 0, 9, 15);                drain(1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
